// File: rtl/calc_core_n.sv
// calc_core_n: N-digit sequential calculator core between keypad scanner and seven-segment driver.
// Operand entry FSM, signed add/sub/mul with chaining, multi-cycle double-dabble conversion.
// Optional memory register (D key) is compiled in when CALC_MEMORY_EN is defined.
module calc_core_n #(
  parameter int unsigned NDIG = 4,
  parameter int unsigned BW   = 16
) (
  input  logic              CLK100MHZ,
  input  logic              reset,
  input  logic              push,
  input  logic [3:0]        digit,
  output logic [4*NDIG-1:0] bcd_out,
  output logic              neg_out,
  output logic [3:0]        operator,
  output logic              error,
  output logic              busy
);

  localparam int unsigned DW  = 4 * NDIG;
  localparam int unsigned RW  = 2 * BW + 1;
  localparam int unsigned CW  = $clog2(BW + 1);
  localparam int unsigned CNW = $clog2(NDIG + 1);

  localparam logic [3:0] KeyAdd = 4'hA;
  localparam logic [3:0] KeySub = 4'hB;
  localparam logic [3:0] KeyMul = 4'hC;
`ifdef CALC_MEMORY_EN
  localparam logic [3:0] KeyMem = 4'hD;
`endif
  localparam logic [3:0] KeyClr = 4'hE;
  localparam logic [3:0] KeyEq  = 4'hF;

  function automatic logic [RW-1:0] max_val();
    logic [RW-1:0] v;
    v = RW'(1);
    for (int unsigned i = 0; i < NDIG; i++) v = v * RW'(10);
    return v - RW'(1);
  endfunction

  localparam logic [RW-1:0] MaxV = max_val();
  localparam logic [BW:0]   TenA = (BW + 1)'(10);
  localparam logic [BW-1:0] TenB = BW'(10);

  typedef enum logic [2:0] {StEnterA, StEnterB, StCalc, StConv, StShowR} state_e;

  state_e state_q, state_d;

  logic                  push_q;
  logic signed [BW:0]    a_q;
  logic [BW-1:0]         b_q;
  logic [CNW-1:0]        cnt_q;
  logic [DW-1:0]         bcd_q;
  logic                  neg_q;
  logic [3:0]            op_q;
  logic                  err_q;
  logic signed [BW:0]    res_q;
  logic [BW-1:0]         bin_q;
  logic [DW-1:0]         dig_q;
  logic [CW-1:0]         conv_q;
`ifdef CALC_MEMORY_EN
  logic signed [BW:0]    mem_q;
  logic [DW-1:0]         mem_bcd_q;
`endif

  logic                  key, live, is_dig, is_op, is_clr;
  logic signed [RW-1:0]  a_ext, b_ext, calc_r;
  logic [RW-1:0]         r_mag;
  logic                  ovf;
  logic signed [BW:0]    a_dig;
  logic [BW-1:0]         b_dig;
  logic [DW-1:0]         bcd_dig;
  logic [DW-1:0]         dd_adj, dd_next;
  logic                  conv_last;

  // Key decode: rising edge of push while idle; every key but E is masked by a sticky error
  always_comb begin
    key    = push && !push_q && !busy;
    is_dig = digit <= 4'd9;
    is_op  = (digit == KeyAdd) || (digit == KeySub) || (digit == KeyMul);
    is_clr = key && (digit == KeyClr);
    live   = key && !err_q;
  end

  // Single-cycle arithmetic on sign-extended operands plus magnitude range check
  always_comb begin
    a_ext = {{(RW - BW - 1){a_q[BW]}}, a_q};
    b_ext = {{(RW - BW){1'b0}}, b_q};
    unique case (op_q)
      KeySub:  calc_r = a_ext - b_ext;
      KeyMul:  calc_r = a_ext * b_ext;
      default: calc_r = a_ext + b_ext;
    endcase
    r_mag = calc_r[RW-1] ? -calc_r : calc_r;
    ovf   = r_mag > MaxV;
  end

  // Operand/display values after a digit key; the first digit of an operand starts a fresh display
  always_comb begin
    a_dig   = a_q * TenA + {{(BW - 3){1'b0}}, digit};
    b_dig   = b_q * TenB + {{(BW - 4){1'b0}}, digit};
    bcd_dig = (cnt_q == '0) ? {{(DW - 4){1'b0}}, digit} : {bcd_q[DW-5:0], digit};
  end

  // One double-dabble step: add 3 to each nibble >= 5, then shift in the next binary bit
  always_comb begin
    for (int i = 0; i < int'(NDIG); i++) begin
      dd_adj[4*i +: 4] = (dig_q[4*i +: 4] >= 4'd5) ? dig_q[4*i +: 4] + 4'd3 : dig_q[4*i +: 4];
    end
    dd_next   = {dd_adj[DW-2:0], bin_q[BW-1]};
    conv_last = conv_q == CW'(BW - 1);
  end

  // State register
  always_ff @(posedge CLK100MHZ) begin
    if (reset) state_q <= StEnterA;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (is_clr) begin
      state_d = StEnterA;
    end else begin
      unique case (state_q)
        StEnterA: if (live && is_op) state_d = StEnterB;
        StEnterB: if (live && digit == KeyEq) state_d = StCalc;
        StCalc:   state_d = ovf ? StShowR : StConv;
        StConv:   if (conv_last) state_d = StShowR;
        StShowR: begin
          if (live && is_dig)     state_d = StEnterA;
          else if (live && is_op) state_d = StEnterB;
        end
        default:  state_d = StEnterA;
      endcase
    end
  end

  // Outputs: busy spans CALC and CONV; display comes from registers only
  always_comb begin
    busy     = (state_q == StCalc) || (state_q == StConv);
    bcd_out  = bcd_q;
    neg_out  = neg_q;
    operator = op_q;
    error    = err_q;
  end

  // Datapath registers: operands, display, conversion engine and memory
  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      push_q    <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      cnt_q     <= '0;
      bcd_q     <= '0;
      neg_q     <= 1'b0;
      op_q      <= '0;
      err_q     <= 1'b0;
      res_q     <= '0;
      bin_q     <= '0;
      dig_q     <= '0;
      conv_q    <= '0;
`ifdef CALC_MEMORY_EN
      mem_q     <= '0;
      mem_bcd_q <= '0;
`endif
    end else begin
      push_q <= push;
      if (is_clr) begin
        a_q   <= '0;
        b_q   <= '0;
        cnt_q <= '0;
        bcd_q <= '0;
        neg_q <= 1'b0;
        op_q  <= '0;
        err_q <= 1'b0;
      end else begin
        unique case (state_q)
          StEnterA, StEnterB: begin
            if (live && is_dig && cnt_q < CNW'(NDIG)) begin
              if (state_q == StEnterA) a_q <= a_dig;
              else                     b_q <= b_dig;
              bcd_q <= bcd_dig;
              cnt_q <= cnt_q + CNW'(1);
              if (cnt_q == '0) neg_q <= 1'b0;
            end else if (live && is_op && (state_q == StEnterA || cnt_q == '0)) begin
              op_q <= digit;
              if (state_q == StEnterA) begin
                b_q   <= '0;
                cnt_q <= '0;
              end
`ifdef CALC_MEMORY_EN
            end else if (live && digit == KeyMem && cnt_q == '0) begin
              if (state_q == StEnterA) begin
                a_q   <= mem_q;
                neg_q <= mem_q[BW];
                bcd_q <= mem_bcd_q;
                cnt_q <= CNW'(NDIG);
              end else if (!mem_q[BW]) begin
                // B is never negative, so a negative memory is not recalled into it
                b_q   <= mem_q[BW-1:0];
                neg_q <= 1'b0;
                bcd_q <= mem_bcd_q;
                cnt_q <= CNW'(NDIG);
              end
`endif
            end
          end
          StCalc: begin
            if (ovf) begin
              err_q <= 1'b1;
              bcd_q <= '0;
              neg_q <= 1'b0;
            end else begin
              neg_q  <= calc_r[RW-1];
              res_q  <= calc_r[BW:0];
              bin_q  <= r_mag[BW-1:0];
              dig_q  <= '0;
              conv_q <= '0;
            end
          end
          StConv: begin
            bin_q  <= bin_q << 1;
            dig_q  <= dd_next;
            conv_q <= conv_q + CW'(1);
            // Display only ever receives the finished conversion
            if (conv_last) bcd_q <= dd_next;
          end
          StShowR: begin
            if (live && is_dig) begin
              a_q   <= {{(BW - 3){1'b0}}, digit};
              cnt_q <= CNW'(1);
              neg_q <= 1'b0;
              op_q  <= '0;
              bcd_q <= {{(DW - 4){1'b0}}, digit};
            end else if (live && is_op) begin
              a_q   <= res_q;
              op_q  <= digit;
              b_q   <= '0;
              cnt_q <= '0;
`ifdef CALC_MEMORY_EN
            end else if (live && digit == KeyMem) begin
              mem_q     <= res_q;
              mem_bcd_q <= bcd_q;
`endif
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
